// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port synchronous data memory.
// Each access runs IDLE -> ISSUE -> RESP; read data comes back with the requester's ack pulse.
module data_mem_arbiter #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [31:0]       p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [31:0]       p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                win_q, win_d;
  logic                we_q, we_d;
  logic                oor_q, oor_d;
  logic [31:0]         mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic                p0_ack_q, p0_ack_d, p0_err_q, p0_err_d, p0_rd_q, p0_rd_d;
  logic                p1_ack_q, p1_ack_d, p1_err_q, p1_err_d, p1_rd_q, p1_rd_d;

  logic                sel;
  logic                sel_we;
  logic [31:0]         sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_oor;

  always_comb begin
    sel       = (p0_req && p1_req) ? rr_ptr_q : p1_req;
    sel_we    = sel ? p1_we    : p0_we;
    sel_addr  = sel ? p1_addr  : p0_addr;
    sel_wdata = sel ? p1_wdata : p0_wdata;
    sel_oor   = (sel_addr >= 32'(DEPTH));

    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    win_d         = win_q;
    we_d          = we_q;
    oor_d         = oor_q;
    mem_address_d = '0;
    mem_data_in_d = '0;
    mem_we_d      = 1'b0;
    mem_re_d      = 1'b0;
    p0_ack_d      = 1'b0;
    p0_err_d      = 1'b0;
    p0_rd_d       = 1'b0;
    p1_ack_d      = 1'b0;
    p1_err_d      = 1'b0;
    p1_rd_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          win_d   = sel;
          we_d    = sel_we;
          oor_d   = sel_oor;
          state_d = ISSUE;
          // Memory strobes are registered here so they are valid throughout ISSUE.
          if (!sel_oor) begin
            mem_address_d = sel_addr;
            mem_data_in_d = sel_wdata;
            mem_we_d      = sel_we;
            mem_re_d      = ~sel_we;
          end
        end
      end
      ISSUE: begin
        p0_ack_d = ~win_q;
        p1_ack_d = win_q;
        p0_err_d = ~win_q & oor_q;
        p1_err_d = win_q & oor_q;
        p0_rd_d  = ~win_q & ~we_q & ~oor_q;
        p1_rd_d  = win_q & ~we_q & ~oor_q;
        state_d  = RESP;
      end
      RESP: begin
        rr_ptr_d = ~win_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= 1'b0;
      win_q         <= 1'b0;
      we_q          <= 1'b0;
      oor_q         <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      p0_ack_q      <= 1'b0;
      p0_err_q      <= 1'b0;
      p0_rd_q       <= 1'b0;
      p1_ack_q      <= 1'b0;
      p1_err_q      <= 1'b0;
      p1_rd_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      win_q         <= win_d;
      we_q          <= we_d;
      oor_q         <= oor_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
      p0_ack_q      <= p0_ack_d;
      p0_err_q      <= p0_err_d;
      p0_rd_q       <= p0_rd_d;
      p1_ack_q      <= p1_ack_d;
      p1_err_q      <= p1_err_d;
      p1_rd_q       <= p1_rd_d;
    end
  end

  // Memory output register already provides the stage; gate it by a registered select.
  assign p0_rdata    = p0_rd_q ? mem_data_out : '0;
  assign p1_rdata    = p1_rd_q ? mem_data_out : '0;
  assign p0_ack      = p0_ack_q;
  assign p0_err      = p0_err_q;
  assign p1_ack      = p1_ack_q;
  assign p1_err      = p1_err_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: vector table of single accesses plus hand-written
// reset, contention and held-request sequences against a behavioural memory.
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_req, p0_we, p0_ack, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_ack, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_we, mem_re, busy;

  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;
  int we_pulses = 0;

  data_mem_arbiter #(.DEPTH(1024), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_we(mem_we), .mem_re(mem_re), .mem_data_out(mem_data_out),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory, 1-cycle read latency.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_address[9:0]] <= mem_data_in;
    if (mem_re) mem_data_out <= mem[mem_address[9:0]];
  end

  always @(negedge clk) if (mem_we) we_pulses++;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  task automatic do_txn(input int idx, input vec_t v);
    logic [31:0] ack_w, oth_w, err_w, rd_w;
    @(negedge clk);
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("v%0d_issue_busy", idx), {31'b0, busy}, 32'd1);
    check($sformatf("v%0d_issue_addr", idx), mem_address, v.exp_err ? 32'd0 : v.addr);
    check($sformatf("v%0d_issue_din", idx), mem_data_in, v.exp_err ? 32'd0 : v.wdata);
    check($sformatf("v%0d_issue_we", idx), {31'b0, mem_we}, {31'b0, v.we & ~v.exp_err});
    check($sformatf("v%0d_issue_re", idx), {31'b0, mem_re}, {31'b0, ~v.we & ~v.exp_err});
    @(negedge clk);
    ack_w = v.port ? {31'b0, p1_ack} : {31'b0, p0_ack};
    oth_w = v.port ? {31'b0, p0_ack} : {31'b0, p1_ack};
    err_w = v.port ? {31'b0, p1_err} : {31'b0, p0_err};
    rd_w  = v.port ? p1_rdata : p0_rdata;
    check($sformatf("v%0d_ack", idx), ack_w, 32'd1);
    check($sformatf("v%0d_other_ack", idx), oth_w, 32'd0);
    check($sformatf("v%0d_err", idx), err_w, {31'b0, v.exp_err});
    check($sformatf("v%0d_rdata", idx), rd_w, v.exp_rdata);
    check($sformatf("v%0d_resp_strobes", idx), {30'b0, mem_we, mem_re}, 32'd0);
    drive(v.port, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_idle_busy", idx), {31'b0, busy}, 32'd0);
    check($sformatf("v%0d_idle_ack", idx), {30'b0, p0_ack, p1_ack}, 32'd0);
  endtask

  initial begin
    int we_base, exp_writes;
    int nacks, n0, n1;
    int gport [8];
    int gcyc  [8];

    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

    vecs[0]  = '{1'b1, 1'b0, 32'd3,          32'h0,        1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 1'b0, 32'd5,          32'h0,        1'b0, 32'h05050505};
    vecs[2]  = '{1'b0, 1'b1, 32'd1023,       32'h12345678, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'd1023,       32'h0,        1'b0, 32'h12345678};
    vecs[4]  = '{1'b0, 1'b0, 32'd1024,       32'h0,        1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 32'h10,         32'hAAAA5555, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h10,         32'h0,        1'b0, 32'hAAAA5555};
    vecs[7]  = '{1'b1, 1'b1, 32'h80000000,   32'h77777777, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 32'd0,          32'hCAFEF00D, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'd0,          32'h0,        1'b0, 32'hCAFEF00D};
    vecs[10] = '{1'b1, 1'b0, 32'hFFFFFFFF,   32'h00001234, 1'b1, 32'h0};

    // Reset state
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_mem", {30'b0, mem_we, mem_re}, 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_acks", {28'b0, p0_ack, p0_err, p1_ack, p1_err}, 32'd0);
    check("rst_rdata", p0_rdata | p1_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    preload(10'd3, 32'hDEADBEEF);
    preload(10'd5, 32'h05050505);
    preload(10'h11, 32'h01010101);

    // Reset in the middle of ISSUE of a p0 write to addr 5
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'd5, 32'h55555555);
    @(posedge clk);
    #1;
    check("mid_issue_we", {31'b0, mem_we}, 32'd1);
    check("mid_issue_addr", mem_address, 32'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_mem", {30'b0, mem_we, mem_re}, 32'd0);
    check("mid_rst_addr", mem_address, 32'd0);
    check("mid_rst_din", mem_data_in, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mid_rst_noack%0d", i), {30'b0, p0_ack, p0_err}, 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_idle%0d", i), {30'b0, busy, p0_ack}, 32'd0);
    end

    // Directed vector table
    we_base = we_pulses;
    exp_writes = 0;
    for (int i = 0; i < 11; i++) begin
      do_txn(i, vecs[i]);
      if (vecs[i].we && !vecs[i].exp_err) exp_writes++;
    end
    check("we_pulse_count", 32'(we_pulses - we_base), 32'(exp_writes));

    // Contention from reset, both ports held for two accesses each
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'd3, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
    nacks = 0; n0 = 0; n1 = 0;
    for (int cyc = 0; cyc < 30 && nacks < 4; cyc++) begin
      @(negedge clk);
      if (p0_ack && p1_ack) check("cont_dual_ack", 32'd1, 32'd0);
      if (p0_ack && nacks < 8) begin
        gport[nacks] = 0; gcyc[nacks] = cyc; nacks++; n0++;
        check("cont_p0_rdata", p0_rdata, 32'hDEADBEEF);
        if (n0 == 2) p0_req = 1'b0;
      end else if (p1_ack && nacks < 8) begin
        gport[nacks] = 1; gcyc[nacks] = cyc; nacks++; n1++;
        check("cont_p1_rdata", p1_rdata, 32'hAAAA5555);
        if (n1 == 2) p1_req = 1'b0;
      end
    end
    check("cont_nacks", 32'(nacks), 32'd4);
    for (int i = 0; i < 4 && i < nacks; i++) begin
      check($sformatf("cont_grant%0d", i), 32'(gport[i]), 32'(i % 2));
      if (i > 0) check($sformatf("cont_gap%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("cont_end_busy", {31'b0, busy}, 32'd0);

    // p1 holds req across two reads with different addresses
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("held_addr0", mem_address, 32'h10);
    check("held_re0", {31'b0, mem_re}, 32'd1);
    @(negedge clk);
    check("held_ack0", {31'b0, p1_ack}, 32'd1);
    check("held_rdata0", p1_rdata, 32'hAAAA5555);
    p1_addr = 32'h11;
    @(negedge clk);
    check("held_gap_idle", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("held_addr1", mem_address, 32'h11);
    check("held_re1", {31'b0, mem_re}, 32'd1);
    @(negedge clk);
    check("held_ack1", {31'b0, p1_ack}, 32'd1);
    check("held_rdata1", p1_rdata, 32'h01010101);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("held_end_busy", {31'b0, busy}, 32'd0);
    check("held_end_ack", {31'b0, p1_ack}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port synchronous data memory.
- Port 0 is the CPU load/store unit; port 1 is the DMA/debug loader.
- Round-robin grants on contention, one access at a time.
- Drives the memory's address, data, write-enable and read-enable. Captures the 1-cycle-latency read data and returns it to the granted requester with an ack pulse.

Parameters:
- DEPTH, 1024, number of 32-bit words in the memory; valid addresses are 0..DEPTH-1.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- p0_req  in  1  port 0 request; held with fields stable until p0_ack.
- p0_we  in  1  port 0: 1=write, 0=read.
- p0_addr  in  32  port 0 word address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  port 0 one-cycle completion pulse.
- p0_err  out  1  port 0 address-out-of-range flag, valid with p0_ack.
- p0_rdata  out  DATA_W  port 0 read data, valid with p0_ack.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata: same as port 0, for port 1.
- mem_address  out  32  to memory data_address.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_we  out  1  to memory write enable.
- mem_re  out  1  to memory read enable.
- mem_data_out  in  DATA_W  from memory data_out (registered in memory, 1-cycle latency).
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=0 (port 0 wins first tie). All outputs 0, including mem_* and all ack/err/rdata. An in-flight access is abandoned; no ack is ever issued for it.
- FSM states: IDLE, ISSUE, RESP. All outputs are registered.
- IDLE:
  - If any req=1, select the winner: the only requester, or rr_ptr on a tie.
  - Latch the winner's index, we, addr and wdata; go to ISSUE. Otherwise stay.
- ISSUE (1 cycle):
  - In range (addr < DEPTH): mem_address=addr, mem_data_in=wdata, mem_we=we, mem_re=~we. The memory acts at the closing edge.
  - Out of range: mem_we=mem_re=0, no memory access, error latched.
  - Go to RESP.
- RESP (1 cycle):
  - Winner's ack=1.
  - err=1 if out of range.
  - rdata=mem_data_out for an in-range read, else 0 (writes and errors).
  - mem_we=mem_re=0.
  - rr_ptr <= ~winner.
  - Go to IDLE.
- Outside RESP: ack, err and rdata are 0; mem_we/mem_re are 0 outside ISSUE.
- Latency: req sampled at edge N; ISSUE in cycle N..N+1; ack in cycle N+1..N+2. Throughput is one access per 3 cycles.
- Requester rule: deassert req at the edge ending the ack cycle. If req is still high in IDLE, it is treated as a new request.
- Requests that arrive while busy are held and served in IDLE; requests are never dropped.
- Arbitration is evaluated only in IDLE. Changes to a non-granted port's fields during busy are harmless.
- Round-robin guarantees that, with both ports continuously requesting, grants alternate 0,1,0,1…
- Address bits above the range cause err; there is no wrap or truncation.
- Write-then-read to the same address returns the new data; there is no bypass requirement because accesses are serialized.

Test Plan:
- Reset: assert rst mid-ISSUE of a p0 write to addr 5 -> all outputs 0 immediately, no p0_ack. After release, busy=0 and rr_ptr=0.
- Single read: p1 read addr 3 (preloaded 0xDEADBEEF) -> mem_re=1 with mem_address=3 one cycle after the request edge. Next cycle p1_ack=1, p1_rdata=0xDEADBEEF, p1_err=0.
- Write/readback: p0 write 0x12345678 to addr 1023, then p0 read 1023 -> second ack has rdata=0x12345678. Exactly one mem_we pulse.
- Contention: p0 and p1 request in the same cycle from reset, both held -> grant order 0,1,0,1 over 4 accesses. Each ack lands 3 cycles apart, and no request is lost.
- Out of range: p0 read addr 1024 -> mem_we=mem_re=0 throughout. p0_ack=1, p0_err=1, p0_rdata=0.
- Held req: p1 keeps req=1 for two transactions with different addresses (0x10, 0x11) -> two acks. mem_address shows 0x10 then 0x11, and busy returns to 0 after the last RESP.
